// File: rtl/s_ram_arb_pkg.sv
// rtl/s_ram_arb_pkg.sv - shared state encoding and sizing helper for the S RAM arbiter
package s_ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  // Width of an index over n requesters; never below one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/s_ram_rr_pick.sv
// rtl/s_ram_rr_pick.sv - combinational round-robin winner search starting at ptr
module s_ram_rr_pick
  import s_ram_arb_pkg::*;
#(
  parameter int num_req = 3,
  parameter int pw      = ptr_width(num_req)
) (
  input  logic [num_req-1:0] req,
  input  logic [pw-1:0]      ptr,
  output logic               valid,
  output logic [pw-1:0]      winner
);

  int          sum;
  logic [pw-1:0] idx;

  // Scan from the farthest offset down so the nearest set bit to ptr wins last.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    sum    = 0;
    idx    = '0;
    for (int k = num_req - 1; k >= 0; k--) begin
      sum = int'(ptr) + k;
      if (sum >= num_req) sum = sum - num_req;
      idx = pw'(sum);
      if (req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/s_ram_arbiter.sv
// rtl/s_ram_arbiter.sv - round-robin, non-preemptive arbiter for the single-port S RAM
module s_ram_arbiter
  import s_ram_arb_pkg::*;
#(
  parameter int num_req          = 3,
  parameter int data_width       = 8,
  parameter int s_ram_addr_width = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [num_req-1:0]                    req,
  output logic [num_req-1:0]                    gnt,
  input  logic [num_req-1:0]                    wren_in,
  input  logic [num_req*s_ram_addr_width-1:0]   addr_in,
  input  logic [num_req*data_width-1:0]         data_in,
  output logic                                  s_ram_wren,
  output logic [s_ram_addr_width-1:0]           s_ram_addr,
  output logic [data_width-1:0]                 s_ram_data,
  output logic                                  busy
);

  localparam int            pw       = ptr_width(num_req);
  localparam logic [pw-1:0] last_idx = pw'(num_req - 1);

  arb_state_t          state, state_nxt;
  logic [num_req-1:0]  gnt_nxt;
  logic [pw-1:0]       owner, owner_nxt;
  logic [pw-1:0]       ptr, ptr_nxt;
  logic                pick_valid;
  logic [pw-1:0]       pick_idx;

  logic [s_ram_addr_width-1:0] addr_arr [num_req];
  logic [data_width-1:0]       data_arr [num_req];

  for (genvar i = 0; i < num_req; i++) begin : g_split
    assign addr_arr[i] = addr_in[i*s_ram_addr_width +: s_ram_addr_width];
    assign data_arr[i] = data_in[i*data_width +: data_width];
  end

  s_ram_rr_pick #(
    .num_req (num_req),
    .pw      (pw)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      owner <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt         = GRANT;
          owner_nxt         = pick_idx;
          gnt_nxt           = '0;
          gnt_nxt[pick_idx] = 1'b1;
        end
      end
      GRANT: begin
        // Only the owner's request matters here; others wait for the next IDLE.
        if (!req[owner]) begin
          state_nxt = RELEASE;
          gnt_nxt   = '0;
          ptr_nxt   = (owner == last_idx) ? '0 : owner + pw'(1);
        end
      end
      RELEASE: state_nxt = IDLE;
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  assign busy = |gnt;

  // Driven straight from the registered grant so a reset silences the port at once.
  always_comb begin
    s_ram_wren = 1'b0;
    s_ram_addr = '0;
    s_ram_data = '0;
    if (busy) begin
      s_ram_wren = wren_in[owner];
      s_ram_addr = addr_arr[owner];
      s_ram_data = data_arr[owner];
    end
  end

endmodule
